// File: rtl/fifo_bit_player.sv
// rtl/fifo_bit_player.sv - pops FIFO bytes and replays them LSB-first, one bit per TICK_CNT cycles
//
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous active-high reset
//   run        playback enable, only looked at on byte boundaries
//   empty      FIFO empty flag
//   rd_data    FIFO read data, valid the cycle after rd_en
//   rd_en      one-cycle FIFO pop strobe
//   bit_out    currently displayed bit (0 when nothing is displayed)
//   bit_valid  high while a bit is displayed
//   bit_idx    index of the displayed bit; holds its last value otherwise
//   byte_done  one-cycle pulse after a byte's last bit completes
//   busy       high whenever the player is not idle
//   byte_cnt   number of fully played bytes, wraps at 256
module fifo_bit_player #(
  parameter int DATA_WIDTH = 8,
  parameter int TICK_CNT   = 3_600_000,
  localparam int IDX_W     = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_en,
  output logic                  bit_out,
  output logic                  bit_valid,
  output logic [IDX_W-1:0]      bit_idx,
  output logic                  byte_done,
  output logic                  busy,
  output logic [7:0]            byte_cnt
);

  localparam int TW = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    LOAD = 2'd2,
    SHOW = 2'd3
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [DATA_WIDTH-1:0] shreg;
  logic [TW-1:0]         tick_cnt;
  logic                  last_tick;
  logic                  last_bit;
  logic                  byte_end;
  logic                  start;

  assign last_tick = (tick_cnt == TW'(TICK_CNT - 1));
  assign last_bit  = (bit_idx == IDX_W'(DATA_WIDTH - 1));
  // Final cycle of the final bit: the only place a byte is counted.
  assign byte_end  = (state == SHOW) && last_tick && last_bit;
  // A pop is only launched when the FIFO reports data in the decision cycle.
  assign start     = run && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    rd_en      = 1'b0;
    bit_valid  = 1'b0;
    bit_out    = 1'b0;
    busy       = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (start) state_next = POP;
      end
      POP: begin
        rd_en      = 1'b1;
        state_next = LOAD;
      end
      LOAD: begin
        state_next = SHOW;
      end
      SHOW: begin
        bit_valid = 1'b1;
        bit_out   = shreg[bit_idx];
        if (byte_end) state_next = start ? POP : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg     <= '0;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      byte_cnt  <= '0;
      byte_done <= 1'b0;
    end else begin
      byte_done <= byte_end;
      if (byte_end) byte_cnt <= byte_cnt + 8'd1;
      if (state == LOAD) begin
        shreg    <= rd_data;
        bit_idx  <= '0;
        tick_cnt <= '0;
      end else if (state == SHOW) begin
        if (last_tick) begin
          tick_cnt <= '0;
          // bit_idx stays on the last bit after the byte so it holds while idle.
          if (!last_bit) bit_idx <= bit_idx + IDX_W'(1);
        end else begin
          tick_cnt <= tick_cnt + TW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_bit_player.sv
// tb/tb_fifo_bit_player.sv - self-checking bench for fifo_bit_player
module tb_fifo_bit_player;

  localparam int DW       = 8;
  localparam int TC       = 4;
  localparam int BYTE_LEN = 2 + DW * TC;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic          empty;
  logic [DW-1:0] rd_data;
  logic          rd_en;
  logic          bit_out;
  logic          bit_valid;
  logic [2:0]    bit_idx;
  logic          byte_done;
  logic          busy;
  logic [7:0]    byte_cnt;

  fifo_bit_player #(.DATA_WIDTH(DW), .TICK_CNT(TC)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .empty     (empty),
    .rd_data   (rd_data),
    .rd_en     (rd_en),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .bit_idx   (bit_idx),
    .byte_done (byte_done),
    .busy      (busy),
    .byte_cnt  (byte_cnt)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference: m_pos counts cycles since the pop of the byte in flight
  // (-1 when idle). Offset 0 is the pop, 1 the load, 2.. the displayed bits.
  int            m_pos;
  logic [DW-1:0] m_byte;
  int            m_cnt;
  logic          m_done;
  int            m_idx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos  = -1;
    m_cnt  = 0;
    m_done = 1'b0;
    m_idx  = 0;
  endtask

  task automatic model_start();
    m_pos  = 0;
    m_byte = q[0];
  endtask

  task automatic set_empty();
    empty = (q.size() == 0);
  endtask

  task automatic cycle();
    logic shown;
    int   bi;
    logic popped;
    logic decide;
    @(negedge clk);
    shown = (m_pos >= 2);
    bi    = shown ? (m_pos - 2) / TC : m_idx;
    chk("rd_en",     rd_en,     (m_pos == 0));
    chk("bit_valid", bit_valid, shown);
    chk("bit_out",   bit_out,   shown ? m_byte[bi] : 1'b0);
    chk("bit_idx",   bit_idx,   bi);
    chk("busy",      busy,      (m_pos >= 0));
    chk("byte_done", byte_done, m_done);
    chk("byte_cnt",  byte_cnt,  m_cnt);
    chk("no_underflow", (rd_en && empty), 0);
    if (shown) m_idx = bi;
    popped = rd_en;
    decide = run && !empty;
    if (rst) begin
      model_reset();
    end else begin
      m_done = 1'b0;
      if (m_pos < 0) begin
        if (decide) model_start();
      end else if (m_pos == BYTE_LEN - 1) begin
        m_cnt  = (m_cnt + 1) % 256;
        m_done = 1'b1;
        if (decide) model_start();
        else m_pos = -1;
      end else begin
        m_pos++;
      end
    end
    @(posedge clk);
    #1;
    if (popped) rd_data = (q.size() > 0) ? q.pop_front() : '0;
    set_empty();
  endtask

  task automatic play_until_idle(input int limit);
    int k;
    k = 0;
    cycle();
    while (m_pos >= 0 && k < limit) begin
      cycle();
      k++;
    end
    chk("idle_timeout", (k < limit), 1);
    repeat (3) cycle();
  endtask

  initial begin
    int k;
    rst     = 1'b1;
    run     = 1'b1;
    rd_data = '0;
    model_reset();
    q.push_back(8'hA5);
    set_empty();

    // Reset held with run=1/empty=0: everything stays at zero.
    repeat (3) cycle();
    chk("rst_no_pop", rd_en, 0);
    rst = 1'b0;

    // Single byte 0xA5; FIFO empties after the pop.
    play_until_idle(200);
    chk("single_cnt", byte_cnt, 1);

    // Two bytes back to back.
    q.push_back(8'h01);
    q.push_back(8'h80);
    set_empty();
    play_until_idle(200);
    chk("two_cnt", byte_cnt, 3);

    // Drop run mid-byte with more data queued.
    q.push_back(8'hFF);
    q.push_back(8'h33);
    set_empty();
    k = 0;
    while (m_pos != 2 + 3 * TC && k < 100) begin
      cycle();
      k++;
    end
    chk("reach_bit3", (k < 100), 1);
    run = 1'b0;
    play_until_idle(200);
    chk("drop_busy", busy, 0);
    chk("drop_left", q.size(), 1);
    chk("drop_cnt",  byte_cnt, 4);
    q.delete();
    set_empty();
    run = 1'b1;

    // Asynchronous reset during bit 5.
    q.push_back(8'hC3);
    set_empty();
    k = 0;
    while (m_pos != 2 + 5 * TC + 1 && k < 100) begin
      cycle();
      k++;
    end
    chk("reach_bit5", (k < 100), 1);
    rst = 1'b1;
    #1;
    chk("arst_rd_en",     rd_en,     0);
    chk("arst_bit_out",   bit_out,   0);
    chk("arst_bit_valid", bit_valid, 0);
    chk("arst_bit_idx",   bit_idx,   0);
    chk("arst_byte_done", byte_done, 0);
    chk("arst_busy",      busy,      0);
    chk("arst_byte_cnt",  byte_cnt,  0);
    model_reset();
    q.delete();
    set_empty();
    repeat (2) cycle();
    rst = 1'b0;
    repeat (10) cycle();
    chk("post_rst_cnt",  byte_cnt, 0);
    chk("post_rst_busy", busy, 0);

    // 256 random bytes: counter wraps back to zero.
    for (int i = 0; i < 256; i++) q.push_back(DW'($urandom));
    set_empty();
    play_until_idle(256 * BYTE_LEN + 100);
    chk("wrap_cnt",   byte_cnt, 0);
    chk("wrap_drain", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
